// File: rtl/soc_system_pio_in_conditioner.sv
// Per-bit synchronizer and debounce filter feeding the CPU input PIO.
// Emits a stable level plus registered one-cycle rise/fall/change pulses.
module soc_system_pio_in_conditioner #(
    parameter int                 WIDTH           = 8,
    parameter int                 SYNC_STAGES     = 2,
    parameter int                 DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0]   INIT_VALUE      = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             change_pulse,
    output logic             stable_valid
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {SETTLE, RUN} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [WIDTH-1:0] data_d, rise_d, fall_d;
    logic             change_d, valid_d;

    // Stage boundary: raw pins -> synchronizer chain
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_p[k] <= INIT_VALUE;
        end else begin
            sync_p[0] <= raw_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_p[k] <= sync_p[k-1];
        end
    end

    assign sync_q = sync_p[SYNC_STAGES-1];

    always_comb begin
        state_d  = state_q;
        data_d   = data_out;
        rise_d   = '0;
        fall_d   = '0;
        settle_d = settle_q;
        valid_d  = stable_valid;
        for (int i = 0; i < WIDTH; i++) cnt_d[i] = cnt_q[i];

        case (state_q)
            SETTLE: begin
                data_d   = sync_q;
                settle_d = sat_inc(settle_q);
                for (int i = 0; i < WIDTH; i++) cnt_d[i] = '0;
                if (settle_q == CNT_LAST) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                end
            end
            RUN: begin
                // A mismatch must persist DEBOUNCE_CYCLES samples; any agreement restarts the count
                for (int i = 0; i < WIDTH; i++) begin
                    if (sync_q[i] == data_out[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        data_d[i] = sync_q[i];
                        cnt_d[i]  = '0;
                        rise_d[i] = sync_q[i];
                        fall_d[i] = ~sync_q[i];
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
            end
            default: state_d = SETTLE;
        endcase

        change_d = |(rise_d | fall_d);
    end

    // Stage boundary: debounce decision -> registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SETTLE;
            data_out     <= INIT_VALUE;
            settle_q     <= '0;
            rise_pulse   <= '0;
            fall_pulse   <= '0;
            change_pulse <= 1'b0;
            stable_valid <= 1'b0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            data_out     <= data_d;
            settle_q     <= settle_d;
            rise_pulse   <= rise_d;
            fall_pulse   <= fall_d;
            change_pulse <= change_d;
            stable_valid <= valid_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: tb/tb_soc_system_pio_in_conditioner.sv
// Directed bench for soc_system_pio_in_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_soc_system_pio_in_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] raw_in = 8'h00;
    logic [7:0] data_out, rise_pulse, fall_pulse;
    logic       change_pulse, stable_valid;

    int n_vec = 0;
    int n_err = 0;

    soc_system_pio_in_conditioner #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INIT_VALUE(8'h00)
    ) dut (
        .clk(clk), .reset(reset), .raw_in(raw_in), .data_out(data_out),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .change_pulse(change_pulse), .stable_valid(stable_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic [7:0] r,
                           input logic [7:0] f);
        chk({tag, ".data"}, 32'(data_out), 32'(d));
        chk({tag, ".rise"}, 32'(rise_pulse), 32'(r));
        chk({tag, ".fall"}, 32'(fall_pulse), 32'(f));
        chk({tag, ".chg"}, 32'(change_pulse), 32'(|(r | f)));
    endtask

    // Reset with a given raw level, then run the four settle edges.
    task automatic reset_settle(input logic [7:0] v);
        raw_in = v;
        reset  = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) step();
        chk("settle.valid", 32'(stable_valid), 32'd1);
        chk_out("settle", v, 8'h00, 8'h00);
    endtask

    logic [8:0] bounce;
    int         n_rise;
    int         first_edge;

    initial begin
        // 1: reset with raw 8'hA5
        raw_in = 8'hA5;
        reset  = 1'b1;
        step();
        step();
        chk_out("t1.rst", 8'h00, 8'h00, 8'h00);
        chk("t1.rst.valid", 32'(stable_valid), 32'd0);
        reset = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            step();
            chk("t1.valid", 32'(stable_valid), 32'(e >= 4));
            chk("t1.rise", 32'(rise_pulse), 32'd0);
            chk("t1.fall", 32'(fall_pulse), 32'd0);
            chk("t1.chg", 32'(change_pulse), 32'd0);
        end
        chk("t1.data", 32'(data_out), 32'hA5);

        // 2: single rise, latency SYNC_STAGES+DEBOUNCE_CYCLES
        reset_settle(8'h00);
        raw_in = 8'h01;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk_out("t2", (e >= 6) ? 8'h01 : 8'h00, (e == 6) ? 8'h01 : 8'h00, 8'h00);
        end

        // 3a: three-cycle glitch on bit 3 is rejected
        reset_settle(8'h00);
        raw_in = 8'h08;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 3) raw_in = 8'h00;
            chk_out("t3a", 8'h00, 8'h00, 8'h00);
        end
        // 3b: four-cycle pulse is accepted, then released four edges later
        raw_in = 8'h08;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (e == 4) raw_in = 8'h00;
            chk_out("t3b", (e >= 6 && e < 10) ? 8'h08 : 8'h00,
                    (e == 6) ? 8'h08 : 8'h00, (e == 10) ? 8'h08 : 8'h00);
        end

        // 4: bounce on bit 0, index 0 is applied first
        bounce     = 9'b1_1110_1101;
        n_rise     = 0;
        first_edge = 0;
        for (int e = 1; e <= 16; e++) begin
            raw_in = {7'b0, (e <= 9) ? bounce[e-1] : 1'b1};
            step();
            if (rise_pulse[0]) begin
                n_rise++;
                if (first_edge == 0) first_edge = e;
            end
            chk("t4.fall", 32'(fall_pulse), 32'd0);
        end
        chk("t4.npulse", 32'(n_rise), 32'd1);
        chk("t4.edge", 32'(first_edge), 32'd11);
        chk("t4.data", 32'(data_out), 32'h01);

        // 5: simultaneous rise and fall on opposite nibbles
        reset_settle(8'h0F);
        raw_in = 8'hF0;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk_out("t5", (e >= 6) ? 8'hF0 : 8'h0F,
                    (e == 6) ? 8'hF0 : 8'h00, (e == 6) ? 8'h0F : 8'h00);
        end

        // 6: reset lands on the edge that would have accepted bit 0
        raw_in = 8'hF1;
        for (int e = 1; e <= 5; e++) begin
            step();
            chk_out("t6.pend", 8'hF0, 8'h00, 8'h00);
        end
        reset = 1'b1;
        step();
        chk_out("t6.rst", 8'h00, 8'h00, 8'h00);
        chk("t6.rst.valid", 32'(stable_valid), 32'd0);
        reset = 1'b0;
        step();
        chk("t6.post.rise", 32'(rise_pulse), 32'd0);
        chk("t6.post.fall", 32'(fall_pulse), 32'd0);
        chk("t6.post.chg", 32'(change_pulse), 32'd0);
        chk("t6.post.valid", 32'(stable_valid), 32'd0);
        for (int e = 2; e <= 4; e++) step();
        chk("t6.settle.valid", 32'(stable_valid), 32'd1);
        chk("t6.settle.data", 32'(data_out), 32'hF1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
